// File: rtl/adc_pipe_code_gen.sv
// ---------------------------------------------------------------------------
// adc_pipe_code_gen
//
// Stimulus source for the pipeline ADC back-end. It takes a target output code
// D, either from code_i or from an internal ramp counter. It splits D into
// redundant per-stage codes and presents them time-skewed, so that stage k
// appears k cycles after stage 0. It also emits D, delayed so that it lines up
// with the encoder output, as an expected value for self-test.
//
// Ports
//   clock_i        system clock, rising edge
//   reset_i        synchronous active-high reset
//   enable_i       allows new samples to be accepted
//   src_sel_i      0 = external code_i, 1 = internal ramp counter
//   redund_i       0 = greedy decomposition, 1 = redundancy-exercising
//   code_i         external target code
//   code_valid_i   external code valid
//   code_ready_o   external code accepted when code_valid_i is also high
//   d_stage_o      stage codes, slice k = [k*NUM_BITS_PER_STAGE +: NUM_BITS_PER_STAGE]
//   d_last_stage_o final flash stage code
//   exp_code_o     expected encoder output
//   exp_valid_o    exp_code_o valid this cycle
// ---------------------------------------------------------------------------
module adc_pipe_code_gen #(
    parameter int NUM_BITS           = 3,
    parameter int NUM_BITS_PER_STAGE = 2,
    parameter int REDUNDANCY         = 1,
    parameter int BITS_ADC_STAGE     = 1,
    parameter int RAMP_STEP          = 1,
    localparam int M                 = NUM_BITS_PER_STAGE - REDUNDANCY,
    localparam int NUM_STAGES        = (NUM_BITS - BITS_ADC_STAGE) / M
) (
    input  logic                                     clock_i,
    input  logic                                     reset_i,
    input  logic                                     enable_i,
    input  logic                                     src_sel_i,
    input  logic                                     redund_i,
    input  logic [NUM_BITS-1:0]                      code_i,
    input  logic                                     code_valid_i,
    output logic                                     code_ready_o,
    output logic [NUM_BITS_PER_STAGE*NUM_STAGES-1:0] d_stage_o,
    output logic [BITS_ADC_STAGE-1:0]                d_last_stage_o,
    output logic [NUM_BITS-1:0]                      exp_code_o,
    output logic                                     exp_valid_o
);

    localparam int NBPS = NUM_BITS_PER_STAGE;
    localparam int DW   = NBPS * NUM_STAGES;
    localparam int CMAX = (1 << NBPS) - 2;

    // Stage weights are powers of two, so the weight is carried as a shift amount.
    function automatic int wshift(input int k);
        return (NUM_STAGES - 1 - k) * M + BITS_ADC_STAGE;
    endfunction

    // Largest value that all stages after k (plus the flash stage) can absorb.
    function automatic int cap(input int k);
        int s;
        s = (1 << BITS_ADC_STAGE) - 1;
        for (int j = k + 1; j < NUM_STAGES; j++) begin
            s = s + CMAX * (1 << wshift(j));
        end
        return s;
    endfunction

    logic                      accept_s;
    logic                      use_redund_s;
    logic [NUM_BITS-1:0]       sample_s;
    logic [NUM_BITS-1:0]       ramp_r;
    logic [DW-1:0]             codes_s;
    logic [BITS_ADC_STAGE-1:0] last_s;
    int                        rem_s;
    int                        cg_s;

    assign code_ready_o = enable_i & ~src_sel_i & ~reset_i;

    // Accept qualification and source selection. Idle slots carry a zero sample.
    always_comb begin
        accept_s     = 1'b0;
        sample_s     = '0;
        use_redund_s = 1'b0;
        if (reset_i || !enable_i) begin
            accept_s = 1'b0;
        end else if (src_sel_i) begin
            accept_s = 1'b1;
        end else begin
            accept_s = code_valid_i;
        end
        if (accept_s) begin
            sample_s     = src_sel_i ? ramp_r : code_i;
            use_redund_s = redund_i;
        end else begin
            sample_s     = '0;
            use_redund_s = 1'b0;
        end
    end

    // Decomposition, from the most significant stage down. In redundant mode a
    // stage gives back one unit whenever the later stages can still absorb the
    // larger remainder, so the sum of c_k*w_k plus the last code still equals D.
    always_comb begin
        rem_s   = int'(sample_s);
        cg_s    = 0;
        codes_s = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            cg_s = rem_s >> wshift(k);
            cg_s = (cg_s > CMAX) ? CMAX : cg_s;
            cg_s = (use_redund_s && (cg_s > 0) &&
                    (cap(k) >= rem_s - (cg_s << wshift(k)) + (1 << wshift(k))))
                   ? cg_s - 1 : cg_s;
            rem_s = rem_s - (cg_s << wshift(k));
            codes_s[k*NBPS +: NBPS] = cg_s[NBPS-1:0];
        end
        last_s = rem_s[BITS_ADC_STAGE-1:0];
    end

    // Ramp counter: advances once per ramp accept and wraps at 2^NUM_BITS.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            ramp_r <= '0;
        end else if (enable_i && src_sel_i) begin
            ramp_r <= ramp_r + NUM_BITS'(RAMP_STEP);
        end else begin
            ramp_r <= ramp_r;
        end
    end

    // Triangular skew: slice k passes through k+1 registers. The first register
    // is the decomposition result captured at the accept edge.
    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_slice
        logic [NBPS-1:0] dly_r [0:k];

        // Delay line for stage k.
        always_ff @(posedge clock_i) begin
            if (reset_i) begin
                for (int i = 0; i <= k; i++) begin
                    dly_r[i] <= '0;
                end
            end else begin
                dly_r[0] <= codes_s[k*NBPS +: NBPS];
                for (int i = 1; i <= k; i++) begin
                    dly_r[i] <= dly_r[i-1];
                end
            end
        end

        assign d_stage_o[k*NBPS +: NBPS] = dly_r[k];
    end

    logic [BITS_ADC_STAGE-1:0] last_dly_r [0:NUM_STAGES];
    logic [NUM_BITS-1:0]       exp_dly_r  [0:NUM_STAGES+1];
    logic                      vld_dly_r  [0:NUM_STAGES+1];

    // Delay lines for the flash-stage code and the expected code and valid.
    // The expected value trails the flash code by one cycle to match the encoder.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            for (int i = 0; i <= NUM_STAGES; i++) begin
                last_dly_r[i] <= '0;
            end
            for (int i = 0; i <= NUM_STAGES + 1; i++) begin
                exp_dly_r[i] <= '0;
                vld_dly_r[i] <= 1'b0;
            end
        end else begin
            last_dly_r[0] <= last_s;
            exp_dly_r[0]  <= sample_s;
            vld_dly_r[0]  <= accept_s;
            for (int i = 1; i <= NUM_STAGES; i++) begin
                last_dly_r[i] <= last_dly_r[i-1];
            end
            for (int i = 1; i <= NUM_STAGES + 1; i++) begin
                exp_dly_r[i] <= exp_dly_r[i-1];
                vld_dly_r[i] <= vld_dly_r[i-1];
            end
        end
    end

    assign d_last_stage_o = last_dly_r[NUM_STAGES];
    assign exp_code_o     = exp_dly_r[NUM_STAGES+1];
    assign exp_valid_o    = vld_dly_r[NUM_STAGES+1];

endmodule

// File: tb/tb_adc_pipe_code_gen.sv
// ---------------------------------------------------------------------------
// Testbench for adc_pipe_code_gen with the default parameters:
// 2 stages of weights 4 and 2, plus a 1-bit flash stage of weight 1.
// Stimulus pushes hand-computed {code, c0, c1, last} entries into a queue. A
// monitor pops an entry on every exp_valid_o pulse and checks it against the
// expected code and against the skewed slices recorded earlier.
// ---------------------------------------------------------------------------
module tb_adc_pipe_code_gen;

    logic       clock_i = 1'b0;
    logic       reset_i = 1'b1;
    logic       enable_i = 1'b0;
    logic       src_sel_i = 1'b0;
    logic       redund_i = 1'b0;
    logic [2:0] code_i = 3'd0;
    logic       code_valid_i = 1'b0;
    logic       code_ready_o;
    logic [3:0] d_stage_o;
    logic [0:0] d_last_stage_o;
    logic [2:0] exp_code_o;
    logic       exp_valid_o;

    adc_pipe_code_gen dut (
        .clock_i        (clock_i),
        .reset_i        (reset_i),
        .enable_i       (enable_i),
        .src_sel_i      (src_sel_i),
        .redund_i       (redund_i),
        .code_i         (code_i),
        .code_valid_i   (code_valid_i),
        .code_ready_o   (code_ready_o),
        .d_stage_o      (d_stage_o),
        .d_last_stage_o (d_last_stage_o),
        .exp_code_o     (exp_code_o),
        .exp_valid_o    (exp_valid_o)
    );

    always #5 clock_i = ~clock_i;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] sb_q [$];      // {code[2:0], c0[1:0], c1[1:0], last}
    logic       check_idle = 1'b0;
    logic [1:0] h_s0 [0:3];
    logic [1:0] h_s1 [0:3];
    logic       h_l  [0:3];

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d at %0t", name, act, req, $time);
        end
    endtask

    // Present one external code for one accept edge, then return to idle.
    task automatic send_ext(input logic [2:0] code, input logic red,
                            input logic [1:0] c0, input logic [1:0] c1, input logic l);
        code_i       = code;
        redund_i     = red;
        code_valid_i = 1'b1;
        sb_q.push_back({code, c0, c1, l});
        @(posedge clock_i); #1;
        code_valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock_i); #1;
        end
    endtask

    // Monitor: keep a short history of the slices and check each expected pulse.
    always @(negedge clock_i) begin
        logic [7:0] e;
        for (int i = 3; i > 0; i--) begin
            h_s0[i] = h_s0[i-1];
            h_s1[i] = h_s1[i-1];
            h_l[i]  = h_l[i-1];
        end
        h_s0[0] = d_stage_o[1:0];
        h_s1[0] = d_stage_o[3:2];
        h_l[0]  = d_last_stage_o[0];
        if (exp_valid_o) begin
            if (sb_q.size() == 0) begin
                check("unexpected_exp_valid", 1, 0);
            end else begin
                e = sb_q.pop_front();
                check("exp_code", int'(exp_code_o), int'(e[7:5]));
                check("slice0", int'(h_s0[3]), int'(e[4:3]));
                check("slice1", int'(h_s1[2]), int'(e[2:1]));
                check("last", int'(h_l[1]), int'(e[0]));
                check("sum_invariant", int'(h_s0[3]) * 4 + int'(h_s1[2]) * 2 + int'(h_l[1]),
                      int'(exp_code_o));
            end
        end else if (check_idle) begin
            check("idle_slot_zero", int'({exp_code_o, h_s0[3], h_s1[2], h_l[1]}), 0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 4; i++) begin
            h_s0[i] = 2'd0;
            h_s1[i] = 2'd0;
            h_l[i]  = 1'b0;
        end
        // Reset with valid and enable asserted: nothing is accepted.
        enable_i     = 1'b1;
        code_valid_i = 1'b1;
        code_i       = 3'd7;
        repeat (3) begin
            @(negedge clock_i);
            check("reset_ready", int'(code_ready_o), 0);
            check("reset_outputs", int'({d_stage_o, d_last_stage_o, exp_code_o, exp_valid_o}), 0);
        end
        @(posedge clock_i); #1;
        code_valid_i = 1'b0;
        reset_i      = 1'b0;
        #1;
        check("ready_after_reset", int'(code_ready_o), 1);
        idle(5);

        // Code 5, greedy and redundant.
        send_ext(3'd5, 1'b0, 2'd1, 2'd0, 1'b1);
        idle(5);
        send_ext(3'd5, 1'b1, 2'd0, 2'd2, 1'b1);
        idle(5);

        // Codes 0..7 back to back with alternating redund_i.
        code_valid_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic [2:0] c;
            logic [4:0] t;
            c = 3'(i);
            case (i)
                0: t = 5'b00_00_0;
                1: t = 5'b00_00_1;
                2: t = 5'b00_01_0;
                3: t = 5'b00_01_1;
                4: t = 5'b01_00_0;
                5: t = 5'b00_10_1;
                6: t = 5'b01_01_0;
                default: t = 5'b01_01_1;
            endcase
            code_i   = c;
            redund_i = (i % 2 == 1);
            sb_q.push_back({c, t});
            @(posedge clock_i); #1;
        end
        code_valid_i = 1'b0;
        idle(6);

        // Ramp for 10 cycles: 0..7, 0, 1 (greedy).
        redund_i  = 1'b0;
        src_sel_i = 1'b1;
        #1;
        check("ready_ramp_sel", int'(code_ready_o), 0);
        for (int i = 0; i < 10; i++) begin
            logic [2:0] v;
            v = 3'(i % 8);
            sb_q.push_back({v, 2'(v[2]), 2'(v[1]), v[0]});
            @(posedge clock_i); #1;
        end
        enable_i = 1'b0;
        #1;
        check("ready_disabled", int'(code_ready_o), 0);
        idle(8);
        // The counter held at 2 while enable_i was low.
        enable_i = 1'b1;
        sb_q.push_back({3'd2, 2'd0, 2'd1, 1'b0});
        @(posedge clock_i); #1;
        src_sel_i = 1'b0;
        idle(6);

        // Mid-flight reset drops 3 and 6 and clears the ramp counter.
        code_valid_i = 1'b1;
        code_i = 3'd3;
        @(posedge clock_i); #1;
        code_i = 3'd6;
        @(posedge clock_i); #1;
        code_valid_i = 1'b0;
        reset_i = 1'b1;
        @(posedge clock_i); #1;
        reset_i = 1'b0;
        check("midreset_slices", int'({d_stage_o, d_last_stage_o, exp_valid_o}), 0);
        idle(6);
        src_sel_i = 1'b1;
        sb_q.push_back({3'd0, 2'd0, 2'd0, 1'b0});
        @(posedge clock_i); #1;
        src_sel_i = 1'b0;
        idle(6);

        // Alternate-cycle codes 2, 4, 6 (redundant) with zero slots between.
        check_idle = 1'b1;
        send_ext(3'd2, 1'b1, 2'd0, 2'd1, 1'b0);
        idle(1);
        send_ext(3'd4, 1'b1, 2'd0, 2'd2, 1'b0);
        idle(1);
        send_ext(3'd6, 1'b1, 2'd1, 2'd1, 1'b0);
        idle(6);
        check_idle = 1'b0;

        check("scoreboard_empty", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/adc_pipe_code_gen.md
Name: adc_pipe_code_gen

Overview:
- Digital stimulus source for the pipeline ADC back-end. It is the transmit side of the per-stage code interface that the pipeline encoder consumes.
- Converts a target output code (external, or an internal ramp) into redundant per-stage codes.
- Time-skews the codes so stage k is presented k cycles after stage 0, matching the encoder's accumulation pipeline.
- Emits a delayed expected code aligned with the encoder output, for on-chip self-test and bench checking.

Parameters:
- NUM_BITS, 3: ADC output width.
- NUM_BITS_PER_STAGE, 2: code width per pipeline stage.
- REDUNDANCY, 1: redundant bits per stage.
- BITS_ADC_STAGE, 1: final flash stage width.
- RAMP_STEP, 1: ramp increment per cycle.
- Derived: NUM_STAGES = (NUM_BITS-BITS_ADC_STAGE)/(NUM_BITS_PER_STAGE-REDUNDANCY).
- Derived: M = NUM_BITS_PER_STAGE-REDUNDANCY.
- Derived: weight w_k = 2^((NUM_STAGES-1-k)*M + BITS_ADC_STAGE); final stage weight = 1.
- Derived: CMAX = 2^NUM_BITS_PER_STAGE-2.

Ports:
- clock_i  in  1  system clock, rising edge.
- reset_i  in  1  synchronous, active-high reset.
- enable_i  in  1  allows new samples to be accepted.
- src_sel_i  in  1  0 = external code, 1 = internal ramp.
- redund_i  in  1  0 = greedy decomposition, 1 = redundancy-exercising decomposition.
- code_i  in  NUM_BITS  external target code.
- code_valid_i  in  1  external code valid.
- code_ready_o  out  1  external code accepted this cycle when code_valid_i is also high.
- d_stage_o  out  NUM_BITS_PER_STAGE*NUM_STAGES  stage codes; slice k = [k*NUM_BITS_PER_STAGE +: NUM_BITS_PER_STAGE].
- d_last_stage_o  out  BITS_ADC_STAGE  final stage code.
- exp_code_o  out  NUM_BITS  expected encoder output.
- exp_valid_o  out  1  exp_code_o is valid this cycle.

Behaviour:
- Single clock domain, all flops on rising clock_i, synchronous reset.
- Reset values: all d_stage_o slices, d_last_stage_o, exp_code_o, exp_valid_o and the ramp counter are 0.
- code_ready_o is combinational: enable_i & ~src_sel_i & ~reset_i.
- Accept condition, external source: code_valid_i & code_ready_o at edge E.
- Accept condition, ramp source: enable_i & src_sel_i at edge E. The ramp sample is the current counter value. The counter then adds RAMP_STEP modulo 2^NUM_BITS.
- The ramp counter holds its value while src_sel_i=0 or enable_i=0.
- Throughput: at most one sample per cycle, no stalls, no backpressure beyond code_ready_o.
- Greedy decomposition (redund_i=0), from stage 0 to stage NUM_STAGES-1:
  - Start with rem = D.
  - c_k = min(rem / w_k, CMAX); rem -= c_k*w_k.
  - Final stage code = rem. rem is guaranteed < 2^BITS_ADC_STAGE for legal parameters.
- Redundant decomposition (redund_i=1):
  - Compute the greedy c_k first.
  - If c_k>0 and CAP_k ≥ rem_after_greedy + w_k, use c_k-1.
  - CAP_k = sum over j>k of CMAX*w_j, plus (2^BITS_ADC_STAGE-1).
  - Invariant in both modes: sum of c_k*w_k + last = D exactly, no modulo.
- redund_i and the source value are sampled at E and travel with the sample. Changing them mid-flight does not affect in-flight samples.
- Skew timing for a sample accepted at edge E:
  - Slice k holds c_k for the one cycle after edge E+k.
  - d_last_stage_o holds the final code for the cycle after edge E+NUM_STAGES.
  - Implement as a triangular delay line; the decomposition itself is one registered step.
- Idle slots: any cycle with no accept injects a zero sample. Every slice carrying that slot is 0 and its exp_valid_o stays low.
- Expected output: exp_code_o = D and exp_valid_o = 1 for the one cycle after edge E+NUM_STAGES+1. This aligns with encoder d_o when both blocks share clock and reset.
- Back-to-back accepts produce contiguous exp_valid_o pulses in order.
- enable_i deassert mid-flight: no new accepts; in-flight samples drain normally.
- reset_i mid-flight: at the next edge all delay stages clear. In-flight samples are dropped with no exp_valid_o, and the ramp counter returns to 0.
- Reset has priority over accept in the same cycle.

Test Plan:
- Reset: hold reset_i 3 cycles with code_valid_i=1, enable_i=1 -> code_ready_o=0, all outputs 0, no exp_valid_o.
- External code 5, redund_i=0, accepted at E:
  - slice0=2'b01 after E; slice1=2'b00 after E+1; last=1 after E+2.
  - exp_code_o=5 with exp_valid_o=1 after E+3 only.
- External code 5, redund_i=1 -> slice0=0, slice1=2, last=1 (0*4+2*2+1=5); exp_code_o=5 at E+3.
- Codes 0..7 back-to-back, valid every cycle, alternating redund_i -> eight consecutive exp pulses 0..7.
  - Each stage-code set satisfies the sum invariant.
  - A connected encoder's d_o equals exp_code_o every valid cycle.
- Ramp: src_sel_i=1, enable_i=1 for 10 cycles -> exp_code_o sequence 0,1,...,7,0,1. Deassert enable_i -> counter holds, pipeline drains.
- Mid-flight reset: accept 3 and 6 on consecutive edges, then assert reset_i one cycle -> all slices 0, no exp_valid_o for either, ramp counter 0.
- Gaps: code_valid_i high on alternate cycles with codes 2,4,6 -> zero slots between samples; exp_valid_o pattern 1,0,1,0,1 with values 2,4,6.
